// File: rtl/shift_add_mult.sv
// Sequential shift/add multiplier: WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per request,
// valid/ready on both sides, optional early exit once the remaining multiplier bits are zero.
module shift_add_mult #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_signed,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [2*WIDTH-1:0] o_product,
  output logic               o_valid,
  input  logic               i_ready
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q,   state_d;
  logic [2*WIDTH-1:0]   mcand_q,   mcand_d;
  logic [WIDTH-1:0]     mplier_q,  mplier_d;
  logic [2*WIDTH-1:0]   acc_q,     acc_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic                 neg_q,     neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 valid_q,   valid_d;

  logic [2*WIDTH-1:0]   acc_sum;
  logic [WIDTH-1:0]     mplier_nxt;
  logic                 last_iter;

  // Magnitude as a WIDTH-bit unsigned value; the most-negative input maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    product_d  = product_q;
    valid_d    = valid_q;

    acc_sum    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    mplier_nxt = mplier_q >> 1;
    last_iter  = (cnt_q == CNT_W'(WIDTH - 1)) || (EARLY_EXIT && (mplier_nxt == '0));

    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d  = RUN;
          mcand_d  = {{WIDTH{1'b0}}, magnitude(i_a, i_signed)};
          mplier_d = magnitude(i_b, i_signed);
          neg_d    = i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_nxt;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d   = DONE;
          valid_d   = 1'b1;
          product_d = neg_q ? -acc_sum : acc_sum;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every flop samples its pre-edge _d value.
    if (i_rst) begin
      // NOTE: datapath registers are reset too, so a reset mid-operation leaves no stale product.
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      valid_q   <= valid_d;
    end
  end

  // Ready drops combinationally while reset is asserted.
  assign o_ready   = (state_q == IDLE) && !i_rst;
  assign o_product = product_q;
  assign o_valid   = valid_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Bench for shift_add_mult: directed corner cases plus randomized traffic on an 8-bit
// early-exit instance and a 16-bit fixed-latency instance, checked against an arithmetic model.
module tb_shift_add_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        sg8, sg16, iv8, iv16, ir8, ir16;
  logic        rdy8, val8, rdy16, val16;
  logic [15:0] p8;
  logic [31:0] p16;

  int total = 0;
  int bad   = 0;

  shift_add_mult #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_a(a8), .i_b(b8), .i_signed(sg8), .i_valid(iv8),
    .o_ready(rdy8), .o_product(p8), .o_valid(val8), .i_ready(ir8)
  );

  shift_add_mult #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_a(a16), .i_b(b16), .i_signed(sg16), .i_valid(iv16),
    .o_ready(rdy16), .o_product(p16), .o_valid(val16), .i_ready(ir16)
  );

  // ---------------- instance access helpers (index 0: 8-bit, 1: 16-bit) ----------------
  function automatic int w_of(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  function automatic bit ee_of(input int i);
    return (i == 0);
  endfunction

  function automatic logic get_rdy(input int i);
    return (i == 0) ? rdy8 : rdy16;
  endfunction

  function automatic logic get_val(input int i);
    return (i == 0) ? val8 : val16;
  endfunction

  function automatic logic [31:0] get_prod(input int i);
    return (i == 0) ? {16'h0, p8} : p16;
  endfunction

  task automatic drive(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic sg, input logic v);
    if (i == 0) begin
      a8 = a[7:0]; b8 = b[7:0]; sg8 = sg; iv8 = v;
    end else begin
      a16 = a; b16 = b; sg16 = sg; iv16 = v;
    end
  endtask

  task automatic set_ready(input int i, input logic r);
    if (i == 0) ir8 = r;
    else        ir16 = r;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_prod(input int w, input logic [15:0] a,
                                           input logic [15:0] b, input logic sg);
    longint full, ma, mb, p;
    full = longint'(1) << w;
    ma   = longint'(a) & (full - 1);
    mb   = longint'(b) & (full - 1);
    if (sg) begin
      if (ma >= full / 2) ma = ma - full;
      if (mb >= full / 2) mb = mb - full;
    end
    p = ma * mb;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic int ref_lat(input int w, input bit ee, input logic [15:0] b, input logic sg);
    longint full, m;
    int n;
    if (!ee) return w;
    full = longint'(1) << w;
    m    = longint'(b) & (full - 1);
    if (sg && m >= full / 2) m = full - m;
    n = 0;
    while (m > 0) begin
      n++;
      m = m >> 1;
    end
    return (n == 0) ? 1 : n;
  endfunction

  function automatic logic [15:0] pick(input int w);
    logic [15:0] mask;
    mask = 16'((32'd1 << w) - 1);
    case ($urandom % 8)
      0:       return 16'h0;
      1:       return mask;
      2:       return 16'(32'd1 << (w - 1));
      3:       return 16'h1;
      default: return 16'($urandom) & mask;
    endcase
  endfunction

  // ---------------- operation driver (observes only, no comparisons) ----------------
  // Call near a negedge. Leaves the DUT holding its result in DONE with i_ready low.
  task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic sg,
                        input bit noise, output logic [31:0] prod, output int lat,
                        output int wait_cyc, output bit to);
    to = 1'b0; lat = 0; wait_cyc = 0; prod = '0;
    set_ready(i, 1'b0);
    drive(i, a, b, sg, 1'b1);
    while (!get_rdy(i) && wait_cyc < 50) begin
      @(posedge clk); @(negedge clk);
      wait_cyc++;
    end
    if (!get_rdy(i)) begin
      to = 1'b1;
      drive(i, '0, '0, 1'b0, 1'b0);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    drive(i, 16'($urandom), 16'($urandom), 1'($urandom), noise ? 1'($urandom) : 1'b0);
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (get_val(i)) break;
      if (noise) drive(i, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    to   = !get_val(i);
    prod = get_prod(i);
  endtask

  task automatic release_op(input int i);
    drive(i, '0, '0, 1'b0, 1'b0);
    set_ready(i, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ready(i, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(0, '0, '0, 1'b0, 1'b1);
    drive(1, '0, '0, 1'b0, 1'b1);
    set_ready(0, 1'b0);
    set_ready(1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (rdy8 !== 1'b0 || rdy16 !== 1'b0)
      begin bad++; $display("FAIL reset_ready: got %b/%b want 0/0", rdy8, rdy16); end
    total++;
    if (val8 !== 1'b0 || val16 !== 1'b0)
      begin bad++; $display("FAIL reset_valid: got %b/%b want 0/0", val8, val16); end
    total++;
    if (p8 !== 16'h0 || p16 !== 32'h0)
      begin bad++; $display("FAIL reset_product: got %h/%h want 0/0", p8, p16); end
    drive(0, '0, '0, 1'b0, 1'b0);
    drive(1, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    total++;
    if (rdy8 !== 1'b1 || rdy16 !== 1'b1)
      begin bad++; $display("FAIL reset_release_ready: got %b/%b want 1/1", rdy8, rdy16); end
  endtask

  task automatic test_unsigned_max();
    logic [31:0] p; int lat, wc; bit to;
    run_op(0, 16'd255, 16'd255, 1'b0, 1'b0, p, lat, wc, to);
    total++;
    if (to || p !== 32'h0000FE01) begin bad++; $display("FAIL u8_max: got %h want 0000fe01", p); end
    total++;
    if (lat !== 8) begin bad++; $display("FAIL u8_max_lat: got %0d want 8", lat); end
    release_op(0);
    run_op(1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, p, lat, wc, to);
    total++;
    if (to || p !== 32'hFFFE0001) begin bad++; $display("FAIL u16_max: got %h want fffe0001", p); end
    total++;
    if (lat !== 16) begin bad++; $display("FAIL u16_max_lat: got %0d want 16", lat); end
    release_op(1);
    run_op(1, 16'd1234, 16'd1, 1'b0, 1'b0, p, lat, wc, to);
    total++;
    if (to || p !== 32'd1234 || lat !== 16)
      begin bad++; $display("FAIL u16_noexit: got %0d lat %0d want 1234 lat 16", p, lat); end
    release_op(1);
  endtask

  task automatic test_signed();
    logic [15:0] ta [3] = '{16'h80, 16'hFF, 16'h7F};
    logic [15:0] tb [3] = '{16'h80, 16'h7F, 16'h80};
    logic [31:0] tp [3] = '{32'h4000, 32'hFF81, 32'hC080};
    int          tl [3] = '{8, 7, 8};
    logic [31:0] p; int lat, wc; bit to;
    for (int k = 0; k < 3; k++) begin
      run_op(0, ta[k], tb[k], 1'b1, 1'b0, p, lat, wc, to);
      total++;
      if (to || p !== tp[k] || lat !== tl[k])
        begin bad++; $display("FAIL s8_%0d: got %h lat %0d want %h lat %0d", k, p, lat, tp[k], tl[k]); end
      release_op(0);
    end
    run_op(1, 16'h8000, 16'h8000, 1'b1, 1'b0, p, lat, wc, to);
    total++;
    if (to || p !== 32'h40000000) begin bad++; $display("FAIL s16_minneg: got %h want 40000000", p); end
    release_op(1);
    run_op(1, 16'hFFFF, 16'h0003, 1'b1, 1'b0, p, lat, wc, to);
    total++;
    if (to || p !== 32'hFFFFFFFD) begin bad++; $display("FAIL s16_neg: got %h want fffffffd", p); end
    release_op(1);
  endtask

  task automatic test_early_exit();
    logic [15:0] ta [4] = '{16'd77, 16'd9, 16'd5, 16'hFB};
    logic [15:0] tb [4] = '{16'd0,  16'd3, 16'h80, 16'd0};
    logic        ts [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] tp [4] = '{32'd0, 32'd27, 32'h280, 32'd0};
    int          tl [4] = '{1, 2, 8, 1};
    logic [31:0] p; int lat, wc; bit to;
    for (int k = 0; k < 4; k++) begin
      run_op(0, ta[k], tb[k], ts[k], 1'b0, p, lat, wc, to);
      total++;
      if (to || p !== tp[k] || lat !== tl[k])
        begin bad++; $display("FAIL exit_%0d: got %h lat %0d want %h lat %0d", k, p, lat, tp[k], tl[k]); end
      release_op(0);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] p; int lat, wc; bit to;
    run_op(0, 16'd13, 16'd11, 1'b0, 1'b0, p, lat, wc, to);
    total++;
    if (to || p !== 32'd143 || lat !== 4)
      begin bad++; $display("FAIL bp_first: got %0d lat %0d want 143 lat 4", p, lat); end
    for (int k = 0; k < 5; k++) begin
      drive(0, 16'($urandom), 16'($urandom), 1'b0, 1'b1);
      @(posedge clk); @(negedge clk);
      total++;
      if (val8 !== 1'b1 || p8 !== 16'd143 || rdy8 !== 1'b0)
        begin bad++; $display("FAIL bp_hold_%0d: got v=%b p=%0d r=%b want 1 143 0", k, val8, p8, rdy8); end
    end
    drive(0, '0, '0, 1'b0, 1'b0);
    set_ready(0, 1'b1);
    @(posedge clk); @(negedge clk);
    set_ready(0, 1'b0);
    total++;
    if (val8 !== 1'b0 || rdy8 !== 1'b1 || p8 !== 16'd143)
      begin bad++; $display("FAIL bp_release: got v=%b r=%b p=%0d want 0 1 143", val8, rdy8, p8); end
    run_op(0, 16'd6, 16'd7, 1'b0, 1'b0, p, lat, wc, to);
    total++;
    if (to || wc !== 0 || p !== 32'd42 || lat !== 3)
      begin bad++; $display("FAIL bp_next: got %0d lat %0d wait %0d want 42 lat 3 wait 0", p, lat, wc); end
    release_op(0);
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] p; int lat, wc; bit to, seen;
    drive(0, 16'd255, 16'd255, 1'b0, 1'b1);
    @(posedge clk); @(negedge clk);
    drive(0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    total++;
    if (val8 !== 1'b0 || p8 !== 16'h0 || rdy8 !== 1'b0)
      begin bad++; $display("FAIL midrst_state: got v=%b p=%h r=%b want 0 0 0", val8, p8, rdy8); end
    rst = 1'b0;
    #1;
    total++;
    if (rdy8 !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", rdy8); end
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      seen = seen | val8;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL midrst_novalid: got valid after abort"); end
    run_op(0, 16'd200, 16'd3, 1'b0, 1'b0, p, lat, wc, to);
    total++;
    if (to || p !== 32'd600 || lat !== 2)
      begin bad++; $display("FAIL midrst_next: got %0d lat %0d want 600 lat 2", p, lat); end
    release_op(0);
  endtask

  task automatic rand_ops(input int i, input int n);
    logic [31:0] p, held, exp_p; logic [15:0] a, b; logic sg;
    int lat, wc, exp_l, w; bit to;
    w = w_of(i);
    for (int k = 0; k < n; k++) begin
      a  = pick(w);
      b  = pick(w);
      sg = 1'($urandom);
      repeat ($urandom % 3) begin @(posedge clk); @(negedge clk); end
      exp_p = ref_prod(w, a, b, sg);
      exp_l = ref_lat(w, ee_of(i), b, sg);
      run_op(i, a, b, sg, 1'b1, p, lat, wc, to);
      total++;
      if (to || p !== exp_p)
        begin bad++; $display("FAIL rand%0d_prod: a=%h b=%h s=%b got %h want %h", w, a, b, sg, p, exp_p); end
      total++;
      if (lat !== exp_l)
        begin bad++; $display("FAIL rand%0d_lat: a=%h b=%h s=%b got %0d want %0d", w, a, b, sg, lat, exp_l); end
      held = p;
      repeat ($urandom % 4) begin
        drive(i, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        @(posedge clk); @(negedge clk);
        total++;
        if (get_val(i) !== 1'b1 || get_prod(i) !== held)
          begin bad++; $display("FAIL rand%0d_hold: got v=%b p=%h want 1 %h", w, get_val(i), get_prod(i), held); end
      end
      release_op(i);
      total++;
      if (get_val(i) !== 1'b0 || get_rdy(i) !== 1'b1)
        begin bad++; $display("FAIL rand%0d_dup: got v=%b r=%b want 0 1", w, get_val(i), get_rdy(i)); end
    end
  endtask

  task automatic test_random();
    fork
      rand_ops(0, 2000);
      rand_ops(1, 2000);
    join
  endtask

  initial begin
    rst = 1'b1;
    drive(0, '0, '0, 1'b0, 1'b0);
    drive(1, '0, '0, 1'b0, 1'b0);
    set_ready(0, 1'b0);
    set_ready(1, 1'b0);
    test_reset();
    test_unsigned_max();
    test_signed();
    test_early_exit();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
